morse_char_assembler: RTL

MORSE_CHAR_ASSEMBLER -- requirements
Module: morse_char_assembler

---
 rtl/morse_char_assembler_if.sv | 23 ++
 rtl/morse_char_assembler.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/morse_char_assembler_if.sv
// Character output channel of the Morse character assembler.
// Ports (signals):
//   char_out   [7:0] ASCII code of the decoded character or word space
//   char_valid       char_out holds an unconsumed character
//   char_ready       consumer accepts char_out when high with char_valid
// Modports: master (assembler side), slave (consumer side).
interface morse_char_assembler_if;
    logic [7:0] char_out;
    logic       char_valid;
    logic       char_ready;

    modport master (
        output char_out,
        output char_valid,
        input  char_ready
    );

    modport slave (
        input  char_out,
        input  char_valid,
        output char_ready
    );
endinterface

// File: rtl/morse_char_assembler.sv
// Morse character assembler: turns dot/dash level streams into ASCII.
// Ports:
//   clk        clock, rising edge active
//   rst        synchronous active-high reset
//   nokta_in   dot level
//   cizgi_in   dash level
//   char_if    output channel (char_out / char_valid / char_ready)
//   err        one-cycle pulse on any protocol error
//   busy       high while symbols are pending or being discarded
module morse_char_assembler #(
    parameter int unsigned GAP_CHAR = 3,
    parameter int unsigned GAP_WORD = 7
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          nokta_in,
    input  logic                          cizgi_in,
    morse_char_assembler_if.master        char_if,
    output logic                          err,
    output logic                          busy
);
    localparam int unsigned IDLE_W  = 4;
    localparam int unsigned PAT_W   = 5;
    localparam int unsigned CNT_W   = 3;
    localparam int unsigned MAX_SYM = 5;

    localparam logic [IDLE_W-1:0] IDLE_MAX   = '1;
    localparam logic [IDLE_W-1:0] GAP_CHAR_L = IDLE_W'(GAP_CHAR);
    localparam logic [IDLE_W-1:0] GAP_WORD_L = IDLE_W'(GAP_WORD);

    typedef enum logic [1:0] {ST_IDLE, ST_MARK, ST_SPACE, ST_DISCARD} state_t;

    state_t              state_q;
    logic [PAT_W-1:0]    pat_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                lvl_q;
    logic [IDLE_W-1:0]   idle_q;
    logic                armed_q;
    logic [7:0]          out_q;
    logic                valid_q;
    logic                err_q;
    logic                busy_q;

    // Pattern holds symbols oldest-first in the low cnt bits; dot=0, dash=1.
    function automatic logic [7:0] decode(input logic [CNT_W-1:0] n, input logic [PAT_W-1:0] p);
        logic [7:0] c;
        c = 8'h3F;
        case ({n, p})
            8'b001_00000: c = 8'h45; 8'b001_00001: c = 8'h54;
            8'b010_00000: c = 8'h49; 8'b010_00001: c = 8'h41;
            8'b010_00010: c = 8'h4E; 8'b010_00011: c = 8'h4D;
            8'b011_00000: c = 8'h53; 8'b011_00001: c = 8'h55;
            8'b011_00010: c = 8'h52; 8'b011_00011: c = 8'h57;
            8'b011_00100: c = 8'h44; 8'b011_00101: c = 8'h4B;
            8'b011_00110: c = 8'h47; 8'b011_00111: c = 8'h4F;
            8'b100_00000: c = 8'h48; 8'b100_00001: c = 8'h56;
            8'b100_00010: c = 8'h46; 8'b100_00100: c = 8'h4C;
            8'b100_00110: c = 8'h50; 8'b100_00111: c = 8'h4A;
            8'b100_01000: c = 8'h42; 8'b100_01001: c = 8'h58;
            8'b100_01010: c = 8'h43; 8'b100_01011: c = 8'h59;
            8'b100_01100: c = 8'h5A; 8'b100_01101: c = 8'h51;
            8'b101_11111: c = 8'h30; 8'b101_01111: c = 8'h31;
            8'b101_00111: c = 8'h32; 8'b101_00011: c = 8'h33;
            8'b101_00001: c = 8'h34; 8'b101_00000: c = 8'h35;
            8'b101_10000: c = 8'h36; 8'b101_11000: c = 8'h37;
            8'b101_11100: c = 8'h38; 8'b101_11110: c = 8'h39;
            default:      c = 8'h3F;
        endcase
        return c;
    endfunction

    // Input classification and helper values derived from current state.
    logic              mark_c, both_c, quiet_c, gap_char_hit_c, sym_full_c;
    logic [IDLE_W-1:0] idle_inc_c;
    logic [PAT_W-1:0]  app_pat_c;
    logic [CNT_W-1:0]  app_cnt_c;
    logic              close_c, space_c, emit_c;
    logic [7:0]        emit_code_c;

    assign mark_c         = nokta_in ^ cizgi_in;
    assign both_c         = nokta_in & cizgi_in;
    assign quiet_c        = ~(nokta_in | cizgi_in);
    assign idle_inc_c     = (idle_q == IDLE_MAX) ? IDLE_MAX : idle_q + 4'd1;
    assign gap_char_hit_c = quiet_c && (idle_inc_c == GAP_CHAR_L);
    assign app_pat_c      = {pat_q[PAT_W-2:0], lvl_q};
    assign app_cnt_c      = cnt_q + 3'd1;
    assign sym_full_c     = (cnt_q == CNT_W'(MAX_SYM));

    // Character close / word-space events and the code they deliver.
    // A close from MARK only occurs when the gap is a single idle cycle.
    always_comb begin
        close_c     = 1'b0;
        space_c     = 1'b0;
        emit_code_c = 8'h00;
        case (state_q)
            ST_SPACE: begin
                if (gap_char_hit_c) begin
                    close_c     = 1'b1;
                    emit_code_c = decode(cnt_q, pat_q);
                end
            end
            ST_MARK: begin
                if (gap_char_hit_c && !sym_full_c) begin
                    close_c     = 1'b1;
                    emit_code_c = decode(app_cnt_c, app_pat_c);
                end
            end
            ST_IDLE: begin
                if (quiet_c && armed_q && (idle_q != IDLE_MAX) && (idle_inc_c == GAP_WORD_L)) begin
                    space_c     = 1'b1;
                    emit_code_c = 8'h20;
                end
            end
            default: ;
        endcase
        emit_c = close_c | space_c;
    end

    // Main FSM, symbol store and output holding register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pat_q   <= '0;
            cnt_q   <= '0;
            lvl_q   <= 1'b0;
            idle_q  <= '0;
            armed_q <= 1'b0;
            out_q   <= 8'h00;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            err_q  <= 1'b0;
            idle_q <= quiet_c ? idle_inc_c : '0;

            // One-deep holding register: drop new code if still occupied.
            if (emit_c) begin
                if (valid_q && !char_if.char_ready) begin
                    err_q <= 1'b1;
                end else begin
                    out_q   <= emit_code_c;
                    valid_q <= 1'b1;
                end
            end else if (valid_q && char_if.char_ready) begin
                valid_q <= 1'b0;
            end

            if (close_c) begin
                armed_q <= 1'b1;
            end else if (space_c) begin
                armed_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (both_c) begin
                        state_q <= ST_DISCARD; err_q <= 1'b1; armed_q <= 1'b0;
                        pat_q <= '0; cnt_q <= '0; busy_q <= 1'b1;
                    end else if (mark_c) begin
                        state_q <= ST_MARK; lvl_q <= cizgi_in; busy_q <= 1'b1;
                    end
                end
                ST_MARK: begin
                    if (both_c || (!(mark_c && cizgi_in == lvl_q) && sym_full_c)) begin
                        state_q <= ST_DISCARD; err_q <= 1'b1; armed_q <= 1'b0;
                        pat_q <= '0; cnt_q <= '0;
                    end else if (!(mark_c && cizgi_in == lvl_q)) begin
                        // Run ended: append it; a level change opens the next run.
                        pat_q <= app_pat_c;
                        cnt_q <= app_cnt_c;
                        if (mark_c) begin
                            lvl_q <= cizgi_in;
                        end else if (gap_char_hit_c) begin
                            state_q <= ST_IDLE; pat_q <= '0; cnt_q <= '0; busy_q <= 1'b0;
                        end else begin
                            state_q <= ST_SPACE;
                        end
                    end
                end
                ST_SPACE: begin
                    if (both_c) begin
                        state_q <= ST_DISCARD; err_q <= 1'b1; armed_q <= 1'b0;
                        pat_q <= '0; cnt_q <= '0;
                    end else if (mark_c) begin
                        state_q <= ST_MARK; lvl_q <= cizgi_in;
                    end else if (gap_char_hit_c) begin
                        state_q <= ST_IDLE; pat_q <= '0; cnt_q <= '0; busy_q <= 1'b0;
                    end
                end
                ST_DISCARD: begin
                    if (gap_char_hit_c) begin
                        state_q <= ST_IDLE; busy_q <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign char_if.char_out   = out_q;
    assign char_if.char_valid = valid_q;
    assign err                = err_q;
    assign busy               = busy_q;
endmodule
